axi_byte_packer: RTL and testbench
==================================

AXI_BYTE_PACKER -- requirements
Module: axi_byte_packer

Interface
REQ-001 SHALL have parameter: DATA_WIDTH, 64, input/output word width in bits; NB = DATA_WIDTH/8 bytes per word.
REQ-002 SHALL have port: clk  in  1  single clock; all logic on rising edge.
REQ-003 SHALL have port: rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port: in_data  in  DATA_WIDTH  compacted bytes; bytes 0..in_cnt-1 valid, byte 0 oldest.
REQ-005 SHALL have port: in_cnt  in  $clog2(NB+1)  valid byte count, 0..NB.
REQ-006 SHALL have port: in_valid  in  1  beat qualifier; no backpressure to upstream.
REQ-007 SHALL have port: in_last  in  1  last beat of packet; sampled only when in_valid=1.
REQ-008 SHALL have ports: m_tdata  out  DATA_WIDTH, m_tkeep  out  NB, m_tvalid  out  1, m_tlast  out  1, m_tready  in  1  AXI-Stream master.
REQ-009 SHALL have ports: ovf  out  1  one-cycle drop pulse; ovf_sticky  out  1  latched drop flag; err_clr  in  1  clears ovf_sticky.

Function
REQ-010 SHALL append valid input bytes to a residual buffer at byte offset fill, where fill ranges 0..NB-1.
REQ-011 SHALL push one full word (m_tkeep all ones) into the output FIFO whenever fill+in_cnt >= NB; remaining bytes become the new residual.
REQ-012 On in_last, SHALL also push the residual (if nonzero) with low-contiguous tkeep of residual count and m_tlast=1, then set fill=0.
REQ-013 A beat needs W words, W in {0,1,2}; SHALL accept it only if FIFO free entries >= W, else SHALL drop the whole beat, pulse ovf and set ovf_sticky.
REQ-014 After a drop, SHALL discard all beats until and including the next in_last (packet poisoned), emit nothing further for that packet, and set fill=0.
REQ-015 SHALL implement an FSM with states IDLE (fill=0, no open packet), PACK (open packet), DISCARD (poisoned). Transitions: IDLE->PACK on accepted non-last beat; PACK->IDLE on accepted last beat; IDLE/PACK->DISCARD on drop of a non-last beat; DISCARD->IDLE on any in_last.
REQ-016 A packet totalling 0 bytes SHALL produce no output word.
REQ-017 When in_last arrives with in_cnt=0 and fill>0, SHALL emit only the residual word with m_tlast=1.
REQ-018 The output FIFO SHALL have depth 2. m_tvalid = FIFO not empty. Pop on m_tvalid && m_tready. Push and pop in the same cycle SHALL be legal; free-entry count SHALL include the slot being popped.
REQ-019 Latency from accepted in_valid to m_tvalid SHALL be 1 cycle when the FIFO is empty.
REQ-020 When m_tvalid=1 and m_tready=0, m_tdata/m_tkeep/m_tlast SHALL remain stable.
REQ-021 If err_clr and a new drop occur in the same cycle, ovf_sticky SHALL end at 1.

Reset
REQ-022 While rst=1: FSM=IDLE, fill=0, FIFO empty, m_tvalid=0, m_tdata=0, m_tkeep=0, m_tlast=0, ovf=0, ovf_sticky=0, statistics counters 0.
REQ-023 Reset asserted mid-packet SHALL discard the residual and FIFO contents; the first beat after release SHALL start a new packet.

Configuration
REQ-024 With PACKER_STATS_EN defined, SHALL add outputs pkt_cnt (32) and drop_cnt (32): wrapping counters of packets emitted with m_tlast and beats dropped.
REQ-025 Without PACKER_STATS_EN, those ports and counters SHALL NOT exist; all other behaviour SHALL be identical.

Structure
REQ-026 Package axi_pkg SHALL hold the FSM state enum packer_state_t and the function keep_from_cnt(cnt) that returns low-contiguous ones.
REQ-027 The 2-entry output FIFO SHALL be sub-module axi_out_fifo2 (data, keep, last; push/pop; free count).

Verification (NB=8)
REQ-028 Beats cnt 3,3,2(last), m_tready=1 -> one word, tkeep 0xFF, tlast=1, bytes in arrival order.
REQ-029 Beats cnt 8,5(last) -> word tkeep 0xFF tlast=0, then word tkeep 0x1F tlast=1.
REQ-030 Beats cnt 7, then 8(last) -> words tkeep 0xFF then 0x7F tlast=1; FIFO full for one cycle.
REQ-031 m_tready=0, beats cnt 8,8,8(last) -> first two accepted; third dropped, ovf pulse, ovf_sticky=1, no tlast word; next packet cnt 4(last) -> tkeep 0x0F tlast=1.
REQ-032 Beat cnt 0 with last and fill=0 -> no output; rst asserted after cnt 5 non-last -> m_tvalid=0; next cnt 2(last) -> tkeep 0x03.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared types and helpers for the AXI-Stream byte packer.
package axi_pkg;

  localparam int unsigned KEEP_MAX = 128;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PACK    = 2'd1,
    ST_DISCARD = 2'd2
  } packer_state_t;

  // Low-contiguous ones: bits [cnt-1:0] set, all others clear.
  function automatic logic [KEEP_MAX-1:0] keep_from_cnt(input int unsigned cnt);
    logic [KEEP_MAX-1:0] k;
    k = '0;
    for (int unsigned i = 0; i < KEEP_MAX; i++) begin
      if (i < cnt) k = {k[KEEP_MAX-2:0], 1'b1};
    end
    return k;
  endfunction

endpackage

// File: rtl/axi_out_fifo2.sv
// Two-entry output FIFO accepting up to two pushes per cycle.
// o_free_c counts the head slot as free when it is popped this cycle.
module axi_out_fifo2 #(
  parameter int unsigned DW = 64,
  parameter int unsigned NB = DW / 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push0,
  input  logic [DW-1:0] i_data0,
  input  logic [NB-1:0] i_keep0,
  input  logic          i_last0,
  input  logic          i_push1,
  input  logic [DW-1:0] i_data1,
  input  logic [NB-1:0] i_keep1,
  input  logic          i_last1,
  input  logic          i_pop,
  output logic          o_valid,
  output logic [DW-1:0] o_data,
  output logic [NB-1:0] o_keep,
  output logic          o_last,
  output logic [1:0]    o_free_c
);

  localparam int unsigned EW = DW + NB + 1;

  logic [EW-1:0] r_e0, r_e1;
  logic [1:0]    r_cnt;
  logic [EW-1:0] w_e0_nxt, w_e1_nxt, w_head, w_in0, w_in1;
  logic [1:0]    w_cnt_nxt, w_cnt_ap;
  logic          w_pop;

  // Pop first, then append pushes behind the surviving entry.
  always_comb begin
    w_pop     = i_pop && (r_cnt != 2'd0);
    w_cnt_ap  = r_cnt - 2'(w_pop);
    w_head    = w_pop ? r_e1 : r_e0;
    w_in0     = {i_last0, i_keep0, i_data0};
    w_in1     = {i_last1, i_keep1, i_data1};
    w_e0_nxt  = w_head;
    w_e1_nxt  = r_e1;
    if (w_cnt_ap == 2'd0) begin
      if (i_push0) w_e0_nxt = w_in0;
      if (i_push1) w_e1_nxt = w_in1;
    end else begin
      if (i_push0) w_e1_nxt = w_in0;
    end
    w_cnt_nxt = w_cnt_ap + 2'(i_push0) + 2'(i_push1);
    o_free_c  = 2'd2 - w_cnt_ap;
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_e0  <= '0;
      r_e1  <= '0;
      r_cnt <= 2'd0;
    end else begin
      r_e0  <= w_e0_nxt;
      r_e1  <= w_e1_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

  assign o_valid = (r_cnt != 2'd0);
  assign o_data  = r_e0[DW-1:0];
  assign o_keep  = r_e0[DW +: NB];
  assign o_last  = r_e0[EW-1];

endmodule

// File: rtl/axi_byte_packer.sv
// Packs compacted byte beats into full AXI-Stream words; drops whole beats
// (and poisons the rest of the packet) when the output FIFO lacks room.
// Optional statistics outputs pkt_cnt/drop_cnt enabled by PACKER_STATS_EN.
module axi_byte_packer
  import axi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [DATA_WIDTH-1:0]                in_data,
  input  logic [$clog2(DATA_WIDTH/8+1)-1:0]    in_cnt,
  input  logic                                 in_valid,
  input  logic                                 in_last,
  output logic [DATA_WIDTH-1:0]                m_tdata,
  output logic [DATA_WIDTH/8-1:0]              m_tkeep,
  output logic                                 m_tvalid,
  output logic                                 m_tlast,
  input  logic                                 m_tready,
  output logic                                 ovf,
  output logic                                 ovf_sticky,
  input  logic                                 err_clr
`ifdef PACKER_STATS_EN
  ,
  output logic [31:0]                          pkt_cnt,
  output logic [31:0]                          drop_cnt
`endif
);

  localparam int unsigned NB = DATA_WIDTH / 8;
  localparam int unsigned CW = $clog2(NB + 1);
  localparam int unsigned TW = CW + 1;
  localparam int unsigned W2 = 2 * DATA_WIDTH;

  packer_state_t         r_state, w_state_nxt;
  logic [CW-1:0]         r_fill, w_fill_nxt;
  logic [DATA_WIDTH-1:0] r_res, w_res_nxt;
  logic                  r_ovf, r_sticky;

  logic [NB-1:0]         w_in_keep, w_rem_keep;
  logic [DATA_WIDTH-1:0] w_in_mask;
  logic [W2-1:0]         w_comb;
  logic [TW-1:0]         w_total, w_rem;
  logic                  w_full, w_has_rem, w_active, w_accept, w_drop;
  logic [1:0]            w_need, w_free;

  logic                  w_push0, w_push1, w_last0;
  logic [NB-1:0]         w_keep0;

  // Expand per-byte valid bits into a byte mask.
  for (genvar g = 0; g < NB; g++) begin : g_mask
    assign w_in_mask[g*8 +: 8] = {8{w_in_keep[g]}};
  end

  // Merge the new bytes behind the residual and size the beat in words.
  always_comb begin
    w_in_keep  = NB'(keep_from_cnt(32'(in_cnt)));
    w_comb     = (W2'(in_data & w_in_mask) << {r_fill, 3'b000}) | W2'(r_res);
    w_total    = TW'(r_fill) + TW'(in_cnt);
    w_full     = (w_total >= TW'(NB));
    w_rem      = w_full ? (w_total - TW'(NB)) : w_total;
    w_has_rem  = (w_rem != '0);
    w_rem_keep = NB'(keep_from_cnt(32'(w_rem)));
    w_need     = 2'(w_full) + 2'(in_last && w_has_rem);
    w_active   = in_valid && (r_state != ST_DISCARD);
    w_accept   = w_active && (w_free >= w_need);
    w_drop     = w_active && !w_accept;
  end

  // Next-state and FIFO push decode.
  always_comb begin
    w_state_nxt = r_state;
    w_fill_nxt  = r_fill;
    w_res_nxt   = r_res;
    w_push0     = 1'b0;
    w_push1     = 1'b0;
    w_keep0     = w_full ? '1 : w_rem_keep;
    w_last0     = in_last && (!w_full || !w_has_rem);
    case (r_state)
      ST_IDLE, ST_PACK: begin
        if (w_accept) begin
          w_push0     = w_full || (in_last && w_has_rem);
          w_push1     = w_full && in_last && w_has_rem;
          w_fill_nxt  = in_last ? '0 : CW'(w_rem);
          w_res_nxt   = in_last ? '0 :
                        (w_full ? w_comb[W2-1:DATA_WIDTH] : w_comb[DATA_WIDTH-1:0]);
          w_state_nxt = in_last ? ST_IDLE : ST_PACK;
        end else if (w_drop) begin
          w_fill_nxt  = '0;
          w_res_nxt   = '0;
          w_state_nxt = in_last ? ST_IDLE : ST_DISCARD;
        end
      end
      ST_DISCARD: begin
        if (in_valid && in_last) w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_fill_nxt  = '0;
        w_res_nxt   = '0;
      end
    endcase
  end

  // FSM state, fill level and residual bytes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_fill  <= '0;
      r_res   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_fill  <= w_fill_nxt;
      r_res   <= w_res_nxt;
    end
  end

  // Drop pulse and sticky flag; a same-cycle drop wins over err_clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf    <= 1'b0;
      r_sticky <= 1'b0;
    end else begin
      r_ovf <= w_drop;
      if (w_drop)       r_sticky <= 1'b1;
      else if (err_clr) r_sticky <= 1'b0;
    end
  end

  assign ovf        = r_ovf;
  assign ovf_sticky = r_sticky;

  axi_out_fifo2 #(
    .DW (DATA_WIDTH),
    .NB (NB)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .i_push0  (w_push0),
    .i_data0  (w_comb[DATA_WIDTH-1:0]),
    .i_keep0  (w_keep0),
    .i_last0  (w_last0),
    .i_push1  (w_push1),
    .i_data1  (w_comb[W2-1:DATA_WIDTH]),
    .i_keep1  (w_rem_keep),
    .i_last1  (1'b1),
    .i_pop    (m_tready),
    .o_valid  (m_tvalid),
    .o_data   (m_tdata),
    .o_keep   (m_tkeep),
    .o_last   (m_tlast),
    .o_free_c (w_free)
  );

`ifdef PACKER_STATS_EN
  logic [31:0] r_pkt_cnt, r_drop_cnt;

  // Wrapping counters of emitted packets and overflow-dropped beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pkt_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (m_tvalid && m_tready && m_tlast) r_pkt_cnt <= r_pkt_cnt + 32'd1;
      if (w_drop) r_drop_cnt <= r_drop_cnt + 32'd1;
    end
  end

  assign pkt_cnt  = r_pkt_cnt;
  assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_axi_byte_packer.sv
// Self-checking bench for axi_byte_packer (NB=8) using a byte-queue model.
module tb_axi_byte_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] in_data;
  logic [3:0]  in_cnt;
  logic        in_valid, in_last, m_tready, err_clr;
  logic [63:0] m_tdata;
  logic [7:0]  m_tkeep;
  logic        m_tvalid, m_tlast, ovf, ovf_sticky;
`ifdef PACKER_STATS_EN
  logic [31:0] pkt_cnt, drop_cnt;
`endif

  axi_byte_packer #(.DATA_WIDTH(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_cnt     (in_cnt),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .m_tdata    (m_tdata),
    .m_tkeep    (m_tkeep),
    .m_tvalid   (m_tvalid),
    .m_tlast    (m_tlast),
    .m_tready   (m_tready),
    .ovf        (ovf),
    .ovf_sticky (ovf_sticky),
    .err_clr    (err_clr)
`ifdef PACKER_STATS_EN
    ,
    .pkt_cnt    (pkt_cnt),
    .drop_cnt   (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } word_t;

  word_t      exp_q[$];
  word_t      out_log[$];
  logic [7:0] pend[$];
  bit         poisoned;
  bit         exp_ovf, exp_sticky;
  int         total = 0;
  int         bad = 0;
  bit         cmp_en = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Byte-level model: pending bytes form words of 8; FIFO holds at most 2 words.
  always @(posedge clk or posedge rst) begin
    bit    drop;
    int    tot, need, free, rem;
    word_t w;
    if (rst) begin
      exp_q.delete();
      pend.delete();
      poisoned   = 0;
      exp_ovf    = 0;
      exp_sticky = 0;
    end else begin
      drop = 0;
      if (m_tready && exp_q.size() > 0) void'(exp_q.pop_front());
      free = 2 - exp_q.size();
      if (in_valid) begin
        if (poisoned) begin
          if (in_last) poisoned = 0;
        end else begin
          tot  = pend.size() + int'(in_cnt);
          need = (tot >= 8 ? 1 : 0) + ((in_last && (tot % 8) != 0) ? 1 : 0);
          if (need <= free) begin
            for (int i = 0; i < int'(in_cnt); i++) pend.push_back(in_data[i*8 +: 8]);
            if (pend.size() >= 8) begin
              w.d = '0;
              for (int i = 0; i < 8; i++) w.d[i*8 +: 8] = pend.pop_front();
              w.k = 8'hFF;
              w.l = in_last && (pend.size() == 0);
              exp_q.push_back(w);
            end
            if (in_last && pend.size() > 0) begin
              rem = pend.size();
              w.d = '0;
              w.k = '0;
              for (int i = 0; i < rem; i++) begin
                w.d[i*8 +: 8] = pend.pop_front();
                w.k[i] = 1'b1;
              end
              w.l = 1'b1;
              exp_q.push_back(w);
            end
          end else begin
            drop = 1;
            pend.delete();
            poisoned = !in_last;
          end
        end
      end
      exp_ovf = drop;
      if (drop) exp_sticky = 1;
      else if (err_clr) exp_sticky = 0;
    end
  end

  // Compare DUT outputs against the model every cycle; log handshakes.
  always @(negedge clk) begin
    word_t w;
    if (cmp_en) begin
      chk("tvalid", m_tvalid, exp_q.size() != 0);
      if (exp_q.size() != 0 && m_tvalid) begin
        chk("tdata", m_tdata, exp_q[0].d);
        chk("tkeep", m_tkeep, exp_q[0].k);
        chk("tlast", m_tlast, exp_q[0].l);
      end
      chk("ovf", ovf, exp_ovf);
      chk("ovf_sticky", ovf_sticky, exp_sticky);
      if (m_tvalid && m_tready) begin
        w = {m_tdata, m_tkeep, m_tlast};
        out_log.push_back(w);
      end
    end
  end

  task automatic beat(input int cnt, input bit last, input logic [7:0] base);
    for (int i = 0; i < 8; i++) in_data[i*8 +: 8] = (i < cnt) ? base + 8'(i) : 8'hEE;
    in_cnt   = 4'(cnt);
    in_last  = last;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_cnt   = '0;
    in_data  = '1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || m_tvalid) && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk("drain_timeout", k >= 50, 0);
  endtask

  task automatic log_chk(input string nm, input int idx, input logic [63:0] d,
                         input logic [7:0] k, input bit l);
    if (idx >= out_log.size()) begin
      chk({nm, "_present"}, 0, 1);
    end else begin
      chk({nm, "_data"}, out_log[idx].d, d);
      chk({nm, "_keep"}, out_log[idx].k, k);
      chk({nm, "_last"}, out_log[idx].l, l);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    in_valid = 0; in_last = 0; in_cnt = 0; in_data = '0;
    m_tready = 1; err_clr = 0;
    #1 rst = 1;
    @(negedge clk);
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tdata", m_tdata, 0);
    chk("rst_tkeep", m_tkeep, 0);
    chk("rst_tlast", m_tlast, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_sticky", ovf_sticky, 0);
    @(posedge clk); #1;
    rst = 0;
    cmp_en = 1;

    // 3+3+2 bytes -> one full last word; one-cycle latency
    b = out_log.size();
    beat(3, 0, 8'h10); beat(3, 0, 8'h20); beat(2, 1, 8'h30);
    chk("s1_latency", m_tvalid, 1);
    drain();
    log_chk("s1_w0", b, 64'h3130_2221_2012_1110, 8'hFF, 1);
    chk("s1_count", out_log.size() - b, 1);

    // 8 then 5(last)
    b = out_log.size();
    beat(8, 0, 8'h40); beat(5, 1, 8'h50);
    drain();
    log_chk("s2_w0", b,     64'h4746_4544_4342_4140, 8'hFF, 0);
    log_chk("s2_w1", b + 1, 64'h0000_0054_5352_5150, 8'h1F, 1);

    // 7 then 8(last): two words pushed together
    b = out_log.size();
    beat(7, 0, 8'h60); beat(8, 1, 8'h70);
    drain();
    log_chk("s3_w0", b,     64'h7066_6564_6362_6160, 8'hFF, 0);
    log_chk("s3_w1", b + 1, 64'h0077_7675_7473_7271, 8'h7F, 1);

    // Backpressure overflow on the last beat
    m_tready = 0;
    b = out_log.size();
    beat(8, 0, 8'h80); beat(8, 0, 8'h90); beat(8, 1, 8'hA0);
    chk("s4_ovf_pulse", ovf, 1);
    chk("s4_sticky", ovf_sticky, 1);
    idle(1);
    chk("s4_ovf_clear", ovf, 0);
    chk("s4_sticky_hold", ovf_sticky, 1);
    m_tready = 1;
    drain();
    log_chk("s4_w0", b,     64'h8786_8584_8382_8180, 8'hFF, 0);
    log_chk("s4_w1", b + 1, 64'h9796_9594_9392_9190, 8'hFF, 0);
    chk("s4_count", out_log.size() - b, 2);
    b = out_log.size();
    beat(4, 1, 8'hB0);
    drain();
    log_chk("s4_next", b, 64'h0000_0000_B3B2_B1B0, 8'h0F, 1);
    err_clr = 1; idle(1); err_clr = 0;
    chk("s4_err_clr", ovf_sticky, 0);

    // Drop of a non-last beat poisons the rest of the packet
    m_tready = 0;
    b = out_log.size();
    beat(8, 0, 8'hC0); beat(8, 0, 8'hC8); beat(8, 0, 8'hD0);
    m_tready = 1;
    drain();
    beat(3, 0, 8'hE0); beat(2, 1, 8'hE8);
    idle(2);
    chk("s4b_count", out_log.size() - b, 2);
    err_clr = 1; idle(1); err_clr = 0;
    chk("s4b_cleared", ovf_sticky, 0);
    // Drop and err_clr in the same cycle leave sticky set
    m_tready = 0;
    beat(8, 0, 8'h00); beat(8, 0, 8'h08);
    err_clr = 1;
    beat(8, 1, 8'h10);
    err_clr = 0;
    chk("s4c_sticky_wins", ovf_sticky, 1);
    m_tready = 1;
    drain();
    err_clr = 1; idle(1); err_clr = 0;

    // Empty packet, then reset mid-packet
    b = out_log.size();
    beat(0, 1, 8'h00);
    idle(2);
    chk("s5_empty_pkt", out_log.size() - b, 0);
    m_tready = 0;
    beat(8, 0, 8'h10); beat(5, 0, 8'h20);
    chk("s5_pre_rst_valid", m_tvalid, 1);
    rst = 1; #1;
    chk("s5_rst_tvalid", m_tvalid, 0);
    chk("s5_rst_tdata", m_tdata, 0);
    chk("s5_rst_tkeep", m_tkeep, 0);
    @(posedge clk); #1;
    rst = 0;
    m_tready = 1;
    b = out_log.size();
    beat(2, 1, 8'h30);
    drain();
    log_chk("s5_w0", b, 64'h0000_0000_0000_3130, 8'h03, 1);
    chk("s5_count", out_log.size() - b, 1);

    // Last beat with zero bytes flushes the residual
    b = out_log.size();
    beat(3, 0, 8'hE0); beat(0, 1, 8'h00);
    drain();
    log_chk("s6_w0", b, 64'h0000_0000_00E2_E1E0, 8'h07, 1);
    chk("s6_count", out_log.size() - b, 1);

    // Mixed sizes with intermittent backpressure, checked by the model
    for (int i = 0; i < 24; i++) begin
      m_tready = (i % 3) != 0;
      beat((i * 5) % 9, (i % 4) == 3, 8'(i * 16));
    end
    m_tready = 1;
    drain();
    idle(2);

    cmp_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
